// File: rtl/oerv_ifetch.sv
// oerv_ifetch -- instruction fetch front end of the OERV core.
//
// Builds the fetch address from byte-serial PC data, runs one classic
// Wishbone read on the instruction bus, holds the returned word and hands it
// to the opcode and immediate decoders with a one-cycle o_wb_en strobe.
//
// Ports:
//   i_clk, i_rst     clock, asynchronous active-high reset
//   i_pc_en          PC byte valid this cycle (accepted only while idle)
//   i_pc_byte[7:0]   PC byte, least significant byte first
//   i_fetch          start a fetch of the assembled address
//   i_flush          discard any pending or held instruction
//   i_dec_ready      decoder can accept an instruction
//   o_ibus_adr[31:0] instruction bus address, always word aligned
//   o_ibus_cyc       instruction bus cycle/strobe
//   i_ibus_rdt[31:0] instruction bus read data
//   i_ibus_ack       instruction bus acknowledge
//   o_wb_en          one-cycle instruction-valid strobe to the decoders
//   o_wb_rdt[29:0]   instruction bits [31:2]
//   o_misalign       one-cycle pulse on a fetch of a non-word-aligned PC
//   o_busy           high whenever a fetch is in flight or a word is held
//
// Decoder handshake: a held word is offered while the state is HOLD. The
// decoder takes it on any edge where i_dec_ready is high (and no flush is
// present); o_wb_en then pulses for exactly the following cycle and o_wb_rdt
// stays unchanged through and after that pulse.
module oerv_ifetch #(
   parameter logic [31:0] RESET_PC = 32'h00000000
) (
   input  logic        i_clk,
   input  logic        i_rst,
   input  logic        i_pc_en,
   input  logic [7:0]  i_pc_byte,
   input  logic        i_fetch,
   input  logic        i_flush,
   input  logic        i_dec_ready,
   output logic [31:0] o_ibus_adr,
   output logic        o_ibus_cyc,
   input  logic [31:0] i_ibus_rdt,
   input  logic        i_ibus_ack,
   output logic        o_wb_en,
   output logic [29:0] o_wb_rdt,
   output logic        o_misalign,
   output logic        o_busy
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      REQ  = 2'd1,
      HOLD = 2'd2
   } state_t;

   state_t      r_state;
   logic [31:0] r_adr_sr;
   logic [1:0]  r_byte_cnt;
   logic        r_cyc;
   logic        r_wb_en;
   logic        r_misalign;
   logic        r_flush_pend;
   logic [29:0] r_wb_rdt;

   logic        w_adr_aligned;

   assign w_adr_aligned = (r_adr_sr[1:0] == 2'b00);

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_state      <= IDLE;
         r_adr_sr     <= RESET_PC;
         r_byte_cnt   <= 2'd0;
         r_cyc        <= 1'b0;
         r_wb_en      <= 1'b0;
         r_misalign   <= 1'b0;
         r_flush_pend <= 1'b0;
         r_wb_rdt     <= 30'd0;
      end else begin
         // Both strobes are single-cycle pulses by construction.
         r_wb_en    <= 1'b0;
         r_misalign <= 1'b0;
         case (r_state)
            IDLE: begin
               if (i_pc_en) begin
                  r_adr_sr   <= {i_pc_byte, r_adr_sr[31:8]};
                  r_byte_cnt <= r_byte_cnt + 2'd1;
               end
               // The alignment test sees the address before this cycle's
               // shift, so a fetch coincident with i_pc_en uses the old PC.
               if (i_fetch) begin
                  if (!w_adr_aligned) begin
                     r_misalign <= 1'b1;
                  end else begin
                     r_state <= REQ;
                     r_cyc   <= 1'b1;
                  end
               end
            end
            REQ: begin
               // A Wishbone cycle cannot be aborted: a flush is only
               // remembered here and acted upon when the ack arrives.
               if (i_ibus_ack) begin
                  r_cyc    <= 1'b0;
                  r_wb_rdt <= i_ibus_rdt[31:2];
                  if (r_flush_pend || i_flush) begin
                     r_flush_pend <= 1'b0;
                     r_state      <= IDLE;
                  end else begin
                     r_state <= HOLD;
                  end
               end else if (i_flush) begin
                  r_flush_pend <= 1'b1;
               end
            end
            HOLD: begin
               if (i_flush) begin
                  r_state <= IDLE;
               end else if (i_dec_ready) begin
                  r_wb_en <= 1'b1;
                  r_state <= IDLE;
               end
            end
            default: begin
               r_state <= IDLE;
               r_cyc   <= 1'b0;
            end
         endcase
      end
   end

   assign o_ibus_adr = {r_adr_sr[31:2], 2'b00};
   assign o_ibus_cyc = r_cyc;
   assign o_wb_en    = r_wb_en;
   assign o_wb_rdt   = r_wb_rdt;
   assign o_misalign = r_misalign;
   assign o_busy     = (r_state != IDLE);

endmodule

// File: tb/tb_oerv_ifetch.sv
// Testbench for oerv_ifetch: table of per-cycle vectors (inputs plus the
// outputs expected just after the following clock edge), and a hand-written
// sequence for asynchronous reset in the middle of a bus cycle.
module tb_oerv_ifetch;

   logic        clk;
   logic        rst;
   logic        pc_en;
   logic [7:0]  pc_byte;
   logic        fetch;
   logic        flush;
   logic        dec_ready;
   logic [31:0] ibus_adr;
   logic        ibus_cyc;
   logic [31:0] ibus_rdt;
   logic        ibus_ack;
   logic        wb_en;
   logic [29:0] wb_rdt;
   logic        misalign;
   logic        busy;

   int n_cmp  = 0;
   int n_fail = 0;

   oerv_ifetch #(.RESET_PC(32'h00000000)) dut (
      .i_clk       (clk),
      .i_rst       (rst),
      .i_pc_en     (pc_en),
      .i_pc_byte   (pc_byte),
      .i_fetch     (fetch),
      .i_flush     (flush),
      .i_dec_ready (dec_ready),
      .o_ibus_adr  (ibus_adr),
      .o_ibus_cyc  (ibus_cyc),
      .i_ibus_rdt  (ibus_rdt),
      .i_ibus_ack  (ibus_ack),
      .o_wb_en     (wb_en),
      .o_wb_rdt    (wb_rdt),
      .o_misalign  (misalign),
      .o_busy      (busy)
   );

   // ---------------- clock / watchdog ----------------
   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached, summary not printed by test");
      $fatal(1, "watchdog");
   end

   // ---------------- vector table ----------------
   typedef struct {
      string       tag;
      logic        pc_en;
      logic [7:0]  pc_byte;
      logic        fetch;
      logic        flush;
      logic        dec_ready;
      logic        ack;
      logic [31:0] rdt;
      logic        e_cyc;
      logic [31:0] e_adr;
      logic        e_wb_en;
      logic [29:0] e_rdt;
      logic        e_mis;
      logic        e_busy;
   } vec_t;

   vec_t vec_q[$];

   function automatic vec_t mk(input string tag, input logic pe, input logic [7:0] pb,
                               input logic f, input logic fl, input logic dr, input logic ak,
                               input logic [31:0] rd, input logic ec, input logic [31:0] ea,
                               input logic ew, input logic [29:0] er, input logic em,
                               input logic eb);
      vec_t v;
      v.tag = tag; v.pc_en = pe; v.pc_byte = pb; v.fetch = f; v.flush = fl;
      v.dec_ready = dr; v.ack = ak; v.rdt = rd; v.e_cyc = ec; v.e_adr = ea;
      v.e_wb_en = ew; v.e_rdt = er; v.e_mis = em; v.e_busy = eb;
      return v;
   endfunction

   // ---------------- checking ----------------
   task automatic check(input string name, input logic [65:0] act, input logic [65:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: {cyc,adr,wb_en,rdt,mis,busy} got %h required %h", name, act, exp);
      end
   endtask

   function automatic logic [65:0] outs();
      return {ibus_cyc, ibus_adr, wb_en, wb_rdt, misalign, busy};
   endfunction

   // Drive one vector, clock once, compare the outputs just after the edge.
   task automatic apply(input vec_t v);
      pc_en     = v.pc_en;
      pc_byte   = v.pc_byte;
      fetch     = v.fetch;
      flush     = v.flush;
      dec_ready = v.dec_ready;
      ibus_ack  = v.ack;
      ibus_rdt  = v.rdt;
      @(posedge clk);
      #1;
      check(v.tag, outs(), {v.e_cyc, v.e_adr, v.e_wb_en, v.e_rdt, v.e_mis, v.e_busy});
   endtask

   task automatic idle_inputs();
      pc_en = 0; pc_byte = 8'h00; fetch = 0; flush = 0;
      dec_ready = 0; ibus_ack = 0; ibus_rdt = 32'h0;
   endtask

   // ---------------- test ----------------
   initial begin
      idle_inputs();
      rst = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      check("reset_state", outs(), {1'b0, 32'h0, 1'b0, 30'h0, 1'b0, 1'b0});
      @(negedge clk);
      rst = 1'b0;

      //             tag          pe  byte  f  fl dr ak  rdt           cyc adr           wb rdt            mis busy
      // Basic fetch of 0x100, decoder ready.
      vec_q.push_back(mk("t1_b0",   1, 8'h00, 0, 0, 0, 0, 32'h0,        0, 32'h00000000, 0, 30'h0,        0, 0));
      vec_q.push_back(mk("t1_b1",   1, 8'h01, 0, 0, 0, 0, 32'h0,        0, 32'h01000000, 0, 30'h0,        0, 0));
      vec_q.push_back(mk("t1_b2",   1, 8'h00, 0, 0, 0, 0, 32'h0,        0, 32'h00010000, 0, 30'h0,        0, 0));
      vec_q.push_back(mk("t1_b3",   1, 8'h00, 0, 0, 0, 0, 32'h0,        0, 32'h00000100, 0, 30'h0,        0, 0));
      vec_q.push_back(mk("t1_fet",  0, 8'h00, 1, 0, 0, 0, 32'h0,        1, 32'h00000100, 0, 30'h0,        0, 1));
      vec_q.push_back(mk("t1_wait", 0, 8'h00, 0, 0, 0, 0, 32'h0,        1, 32'h00000100, 0, 30'h0,        0, 1));
      vec_q.push_back(mk("t1_ack",  0, 8'h00, 0, 0, 1, 1, 32'h00A00093, 0, 32'h00000100, 0, 30'h00280024, 0, 1));
      vec_q.push_back(mk("t1_wben", 0, 8'h00, 0, 0, 1, 0, 32'h0,        0, 32'h00000100, 1, 30'h00280024, 0, 0));
      vec_q.push_back(mk("t1_post", 0, 8'h00, 0, 0, 1, 0, 32'h0,        0, 32'h00000100, 0, 30'h00280024, 0, 0));
      // Misaligned PC 0x102.
      vec_q.push_back(mk("t2_b0",   1, 8'h02, 0, 0, 0, 0, 32'h0,        0, 32'h02000000, 0, 30'h00280024, 0, 0));
      vec_q.push_back(mk("t2_b1",   1, 8'h01, 0, 0, 0, 0, 32'h0,        0, 32'h01020000, 0, 30'h00280024, 0, 0));
      vec_q.push_back(mk("t2_b2",   1, 8'h00, 0, 0, 0, 0, 32'h0,        0, 32'h00010200, 0, 30'h00280024, 0, 0));
      vec_q.push_back(mk("t2_b3",   1, 8'h00, 0, 0, 0, 0, 32'h0,        0, 32'h00000100, 0, 30'h00280024, 0, 0));
      vec_q.push_back(mk("t2_fet",  0, 8'h00, 1, 0, 0, 0, 32'h0,        0, 32'h00000100, 0, 30'h00280024, 1, 0));
      vec_q.push_back(mk("t2_post", 0, 8'h00, 0, 0, 0, 0, 32'h0,        0, 32'h00000100, 0, 30'h00280024, 0, 0));
      // Fetch 0x200, decoder stalls in HOLD; PC bytes, fetch, ack ignored there.
      vec_q.push_back(mk("t3_b0",   1, 8'h00, 0, 0, 0, 0, 32'h0,        0, 32'h00000000, 0, 30'h00280024, 0, 0));
      vec_q.push_back(mk("t3_b1",   1, 8'h02, 0, 0, 0, 0, 32'h0,        0, 32'h02000000, 0, 30'h00280024, 0, 0));
      vec_q.push_back(mk("t3_b2",   1, 8'h00, 0, 0, 0, 0, 32'h0,        0, 32'h00020000, 0, 30'h00280024, 0, 0));
      vec_q.push_back(mk("t3_b3",   1, 8'h00, 0, 0, 0, 0, 32'h0,        0, 32'h00000200, 0, 30'h00280024, 0, 0));
      vec_q.push_back(mk("t3_fet",  0, 8'h00, 1, 0, 0, 0, 32'h0,        1, 32'h00000200, 0, 30'h00280024, 0, 1));
      vec_q.push_back(mk("t3_ack",  0, 8'h00, 0, 0, 0, 1, 32'hDEADBEEF, 0, 32'h00000200, 0, 30'h37AB6FBB, 0, 1));
      vec_q.push_back(mk("t3_h1",   0, 8'h00, 0, 0, 0, 0, 32'h0,        0, 32'h00000200, 0, 30'h37AB6FBB, 0, 1));
      vec_q.push_back(mk("t3_h2pc", 1, 8'hFF, 0, 0, 0, 0, 32'h0,        0, 32'h00000200, 0, 30'h37AB6FBB, 0, 1));
      vec_q.push_back(mk("t3_h3f",  0, 8'h00, 1, 0, 0, 0, 32'h0,        0, 32'h00000200, 0, 30'h37AB6FBB, 0, 1));
      vec_q.push_back(mk("t3_h4ak", 0, 8'h00, 0, 0, 0, 1, 32'h55555555, 0, 32'h00000200, 0, 30'h37AB6FBB, 0, 1));
      vec_q.push_back(mk("t3_h5",   0, 8'h00, 0, 0, 0, 0, 32'h0,        0, 32'h00000200, 0, 30'h37AB6FBB, 0, 1));
      vec_q.push_back(mk("t3_wben", 0, 8'h00, 0, 0, 1, 0, 32'h0,        0, 32'h00000200, 1, 30'h37AB6FBB, 0, 0));
      vec_q.push_back(mk("t3_post", 0, 8'h00, 0, 0, 1, 0, 32'h0,        0, 32'h00000200, 0, 30'h37AB6FBB, 0, 0));
      // Flush during REQ, ack three cycles later; PC byte/fetch ignored in REQ.
      vec_q.push_back(mk("t4a_fet", 0, 8'h00, 1, 0, 0, 0, 32'h0,        1, 32'h00000200, 0, 30'h37AB6FBB, 0, 1));
      vec_q.push_back(mk("t4a_fl",  0, 8'h00, 0, 1, 0, 0, 32'h0,        1, 32'h00000200, 0, 30'h37AB6FBB, 0, 1));
      vec_q.push_back(mk("t4a_pc",  1, 8'hAA, 1, 0, 0, 0, 32'h0,        1, 32'h00000200, 0, 30'h37AB6FBB, 0, 1));
      vec_q.push_back(mk("t4a_w",   0, 8'h00, 0, 0, 0, 0, 32'h0,        1, 32'h00000200, 0, 30'h37AB6FBB, 0, 1));
      vec_q.push_back(mk("t4a_ack", 0, 8'h00, 0, 0, 1, 1, 32'h12345678, 0, 32'h00000200, 0, 30'h048D159E, 0, 0));
      vec_q.push_back(mk("t4a_pst", 0, 8'h00, 0, 0, 1, 0, 32'h0,        0, 32'h00000200, 0, 30'h048D159E, 0, 0));
      // Flush in the ack cycle.
      vec_q.push_back(mk("t4b_fet", 0, 8'h00, 1, 0, 0, 0, 32'h0,        1, 32'h00000200, 0, 30'h048D159E, 0, 1));
      vec_q.push_back(mk("t4b_ack", 0, 8'h00, 0, 1, 1, 1, 32'h0000000C, 0, 32'h00000200, 0, 30'h00000003, 0, 0));
      vec_q.push_back(mk("t4b_pst", 0, 8'h00, 0, 0, 1, 0, 32'h0,        0, 32'h00000200, 0, 30'h00000003, 0, 0));
      // Flush while held, decoder ready in the same cycle.
      vec_q.push_back(mk("t4c_fet", 0, 8'h00, 1, 0, 0, 0, 32'h0,        1, 32'h00000200, 0, 30'h00000003, 0, 1));
      vec_q.push_back(mk("t4c_ack", 0, 8'h00, 0, 0, 0, 1, 32'hFFFFFFFF, 0, 32'h00000200, 0, 30'h3FFFFFFF, 0, 1));
      vec_q.push_back(mk("t4c_fl",  0, 8'h00, 0, 1, 1, 0, 32'h0,        0, 32'h00000200, 0, 30'h3FFFFFFF, 0, 0));
      vec_q.push_back(mk("t4c_pst", 0, 8'h00, 0, 0, 1, 0, 32'h0,        0, 32'h00000200, 0, 30'h3FFFFFFF, 0, 0));
      // Fetch with PC byte in the same cycle: aligned 0x200 is used, the
      // shifted 0x01000002 (misaligned) only shows up afterwards.
      vec_q.push_back(mk("t6_both", 1, 8'h01, 1, 0, 0, 0, 32'h0,        1, 32'h01000000, 0, 30'h3FFFFFFF, 0, 1));
      vec_q.push_back(mk("t6_ack",  0, 8'h00, 0, 0, 1, 1, 32'h00000013, 0, 32'h01000000, 0, 30'h00000004, 0, 1));
      vec_q.push_back(mk("t6_wben", 0, 8'h00, 0, 0, 1, 0, 32'h0,        0, 32'h01000000, 1, 30'h00000004, 0, 0));
      vec_q.push_back(mk("t6_post", 0, 8'h00, 0, 0, 0, 0, 32'h0,        0, 32'h01000000, 0, 30'h00000004, 0, 0));
      // Load 0x300 and start a fetch for the reset test.
      vec_q.push_back(mk("t5_b0",   1, 8'h00, 0, 0, 0, 0, 32'h0,        0, 32'h00010000, 0, 30'h00000004, 0, 0));
      vec_q.push_back(mk("t5_b1",   1, 8'h03, 0, 0, 0, 0, 32'h0,        0, 32'h03000100, 0, 30'h00000004, 0, 0));
      vec_q.push_back(mk("t5_b2",   1, 8'h00, 0, 0, 0, 0, 32'h0,        0, 32'h00030000, 0, 30'h00000004, 0, 0));
      vec_q.push_back(mk("t5_b3",   1, 8'h00, 0, 0, 0, 0, 32'h0,        0, 32'h00000300, 0, 30'h00000004, 0, 0));
      vec_q.push_back(mk("t5_fet",  0, 8'h00, 1, 0, 0, 0, 32'h0,        1, 32'h00000300, 0, 30'h00000004, 0, 1));

      foreach (vec_q[i]) apply(vec_q[i]);
      idle_inputs();

      // Asynchronous reset mid-REQ: outputs must clear before the next edge.
      #3;
      rst = 1'b1;
      #1;
      check("async_rst_cyc", outs(), {1'b0, 32'h0, 1'b0, 30'h0, 1'b0, 1'b0});
      @(negedge clk);
      rst = 1'b0;

      // After reset a full 4-byte load and a fetch behave normally.
      vec_q.delete();
      vec_q.push_back(mk("r_b0",    1, 8'h00, 0, 0, 0, 0, 32'h0,        0, 32'h00000000, 0, 30'h0,        0, 0));
      vec_q.push_back(mk("r_b1",    1, 8'h04, 0, 0, 0, 0, 32'h0,        0, 32'h04000000, 0, 30'h0,        0, 0));
      vec_q.push_back(mk("r_b2",    1, 8'h00, 0, 0, 0, 0, 32'h0,        0, 32'h00040000, 0, 30'h0,        0, 0));
      vec_q.push_back(mk("r_b3",    1, 8'h00, 0, 0, 0, 0, 32'h0,        0, 32'h00000400, 0, 30'h0,        0, 0));
      vec_q.push_back(mk("r_fet",   0, 8'h00, 1, 0, 0, 0, 32'h0,        1, 32'h00000400, 0, 30'h0,        0, 1));
      vec_q.push_back(mk("r_ack",   0, 8'h00, 0, 0, 1, 1, 32'h00000083, 0, 32'h00000400, 0, 30'h00000020, 0, 1));
      vec_q.push_back(mk("r_wben",  0, 8'h00, 0, 0, 1, 0, 32'h0,        0, 32'h00000400, 1, 30'h00000020, 0, 0));
      vec_q.push_back(mk("r_post",  0, 8'h00, 0, 0, 0, 0, 32'h0,        0, 32'h00000400, 0, 30'h00000020, 0, 0));
      foreach (vec_q[i]) apply(vec_q[i]);
      idle_inputs();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
